// File: rtl/wb_bram_ctrl_if.sv
// wb_bram_ctrl_if: Wishbone classic bus bundle between an interconnect master and the BRAM controller slave
interface wb_bram_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic [31:0]         wb_adr_i;
    logic [DATA_W-1:0]   wb_dat_i;
    logic [DATA_W/8-1:0] wb_sel_i;
    logic [DATA_W-1:0]   wb_dat_o;
    logic                wb_ack_o;
    logic                wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone classic slave bridging to a synchronous block RAM port with configurable read latency
module wb_bram_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 12,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_bram_ctrl_if.slave       wb,
    output logic                ram_en_o,
    output logic [DATA_W/8-1:0] ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);
    localparam int SW  = DATA_W / 8;
    localparam int BO  = $clog2(SW);
    localparam int TOP = ADDR_W + BO;

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_t;

    state_t            state, state_n;
    logic [1:0]        cnt, cnt_n;
    logic              wr, wr_n;
    logic              en_n, ack_n, err_n;
    logic [SW-1:0]     we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n, dat_n;
    logic              hit;
    logic              unused_lsb;

    // byte-offset bits never affect the access; only the bits above the RAM span select the window
    assign unused_lsb = ^wb.wb_adr_i[BO-1:0];
    assign hit        = wb.wb_adr_i[31:TOP] == BASE_ADDR[31:TOP];

    // next state and next registered outputs; everything defaults to idle/hold
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = wr;
        en_n    = 1'b0;
        we_n    = '0;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        addr_n  = ram_addr_o;
        wdata_n = ram_wdata_o;
        dat_n   = wb.wb_dat_o;
        case (state)
            IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    if (hit) begin
                        state_n = ACCESS;
                        en_n    = 1'b1;
                        addr_n  = wb.wb_adr_i[TOP-1:BO];
                        wdata_n = wb.wb_dat_i;
                        wr_n    = wb.wb_we_i;
                        we_n    = wb.wb_we_i ? wb.wb_sel_i : '0;
                        ack_n   = wb.wb_we_i;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_n = wr ? IDLE : WAIT;
                cnt_n   = 2'(RD_LATENCY);
            end
            WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == 2'd1) begin
                    state_n = RESP;
                    cnt_n   = '0;
                    dat_n   = ram_rdata_i;
                    ack_n   = 1'b1;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state, read-latency counter and latched direction
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            wr    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wr    <= wr_n;
        end
    end

    // all bus and RAM outputs come straight from flops
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ram_en_o    <= 1'b0;
            ram_we_o    <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
        end else begin
            ram_en_o    <= en_n;
            ram_we_o    <= we_n;
            ram_addr_o  <= addr_n;
            ram_wdata_o <= wdata_n;
            wb.wb_dat_o <= dat_n;
            wb.wb_ack_o <= ack_n;
            wb.wb_err_o <= err_n;
        end
    end
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: scoreboard bench; instance 0 has latency 1 at base 0, instance 1 has latency 3 at base 0x1000_0000
module tb_wb_bram_ctrl;
    typedef struct { int k; bit is_err; bit chk_dat; logic [31:0] dat; int cyc; } rsp_t;
    typedef struct { int k; logic [3:0] we; logic [11:0] addr; logic [31:0] wdata; int cyc; } ram_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc_n = 0;
    int n_cmp = 0;
    int n_mis = 0;
    rsp_t rq[$];
    ram_t mq[$];

    logic        m_cyc[2], m_stb[2], m_we[2];
    logic [31:0] m_adr[2], m_dat[2];
    logic [3:0]  m_sel[2];
    logic [31:0] s_dat[2];
    logic        s_ack[2], s_err[2], r_en[2];
    logic [3:0]  r_we[2];
    logic [11:0] r_addr[2];
    logic [31:0] r_wdata[2], r_rdata[2];
    logic [31:0] mem0[4096];
    logic [31:0] mem1[4096];
    logic [31:0] pa1, pb1, pb2, pb3;

    wb_bram_ctrl_if #(.DATA_W(32)) ia();
    wb_bram_ctrl_if #(.DATA_W(32)) ib();

    assign ia.wb_cyc_i = m_cyc[0];
    assign ia.wb_stb_i = m_stb[0];
    assign ia.wb_we_i  = m_we[0];
    assign ia.wb_adr_i = m_adr[0];
    assign ia.wb_dat_i = m_dat[0];
    assign ia.wb_sel_i = m_sel[0];
    assign s_dat[0]    = ia.wb_dat_o;
    assign s_ack[0]    = ia.wb_ack_o;
    assign s_err[0]    = ia.wb_err_o;
    assign ib.wb_cyc_i = m_cyc[1];
    assign ib.wb_stb_i = m_stb[1];
    assign ib.wb_we_i  = m_we[1];
    assign ib.wb_adr_i = m_adr[1];
    assign ib.wb_dat_i = m_dat[1];
    assign ib.wb_sel_i = m_sel[1];
    assign s_dat[1]    = ib.wb_dat_o;
    assign s_ack[1]    = ib.wb_ack_o;
    assign s_err[1]    = ib.wb_err_o;
    assign r_rdata[0]  = pa1;
    assign r_rdata[1]  = pb3;

    wb_bram_ctrl #(.DATA_W(32), .ADDR_W(12), .RD_LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(ia),
        .ram_en_o(r_en[0]), .ram_we_o(r_we[0]), .ram_addr_o(r_addr[0]),
        .ram_wdata_o(r_wdata[0]), .ram_rdata_i(r_rdata[0])
    );

    wb_bram_ctrl #(.DATA_W(32), .ADDR_W(12), .RD_LATENCY(3), .BASE_ADDR(32'h1000_0000)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(ib),
        .ram_en_o(r_en[1]), .ram_we_o(r_we[1]), .ram_addr_o(r_addr[1]),
        .ram_wdata_o(r_wdata[1]), .ram_rdata_i(r_rdata[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // RAM models: byte-masked writes; read data is a poison word except in the cycle(s) it is due
    always @(posedge clk) begin
        if (r_en[0] && r_we[0] != 4'h0) mem0[r_addr[0]] <= merge(mem0[r_addr[0]], r_wdata[0], r_we[0]);
        if (r_en[1] && r_we[1] != 4'h0) mem1[r_addr[1]] <= merge(mem1[r_addr[1]], r_wdata[1], r_we[1]);
        pa1 <= (r_en[0] && r_we[0] == 4'h0) ? mem0[r_addr[0]] : 32'hBAD0_BAD0;
        pb1 <= (r_en[1] && r_we[1] == 4'h0) ? mem1[r_addr[1]] : 32'hBAD0_BAD0;
        pb2 <= pb1;
        pb3 <= pb2;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic miss(string nm, int k);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: dut %0d produced an event at cycle %0d, required none", nm, k, cyc_n);
    endtask

    // monitor: pops the expected bus response / RAM access whenever a DUT presents one
    initial begin
        rsp_t e;
        ram_t m;
        bit prev[2];
        prev[0] = 1'b0;
        prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (s_ack[k] || s_err[k]) begin
                    if (rq.size() == 0) miss("unexpected_rsp", k);
                    else begin
                        e = rq.pop_front();
                        chk("rsp_dut", k, e.k);
                        chk("rsp_err", 32'(s_err[k]), 32'(e.is_err));
                        chk("rsp_ack", 32'(s_ack[k]), 32'(!e.is_err));
                        chk("rsp_cycle", cyc_n, e.cyc);
                        if (e.chk_dat) chk("rsp_data", s_dat[k], e.dat);
                    end
                    if (s_ack[k]) chk("ack_gap", 32'(prev[k]), 32'h0);
                end
                if (r_en[k]) begin
                    if (mq.size() == 0) miss("unexpected_ram_en", k);
                    else begin
                        m = mq.pop_front();
                        chk("ram_dut", k, m.k);
                        chk("ram_we", 32'(r_we[k]), 32'(m.we));
                        chk("ram_addr", 32'(r_addr[k]), 32'(m.addr));
                        chk("ram_wdata", r_wdata[k], m.wdata);
                        chk("ram_cycle", cyc_n, m.cyc);
                    end
                end else if (r_we[k] != 4'h0) miss("ram_we_without_en", k);
                prev[k] = s_ack[k];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(int k, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        m_cyc[k] = 1'b1;
        m_stb[k] = 1'b1;
        m_we[k]  = w;
        m_adr[k] = a;
        m_dat[k] = d;
        m_sel[k] = s;
    endtask

    task automatic idle(int k);
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
        m_we[k]  = 1'b0;
    endtask

    task automatic wait_rsp(int k);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = s_ack[k] || s_err[k];
        end
        if (!got) begin
            n_cmp++;
            n_mis++;
            $display("FAIL rsp_timeout: dut %0d gave no ack/err within 20 cycles, required one", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int k, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [11:0] ra, bit hold);
        int c = cyc_n;
        req(k, 1'b1, a, d, s);
        rq.push_back('{k, 1'b0, 1'b0, 32'h0, c + 1});
        mq.push_back('{k, s, ra, d, c + 1});
        wait_rsp(k);
        if (!hold) idle(k);
    endtask

    task automatic rd(int k, logic [31:0] a, logic [31:0] exp, logic [11:0] ra);
        int c = cyc_n;
        int lat = (k == 0) ? 1 : 3;
        req(k, 1'b0, a, 32'h0, 4'hF);
        rq.push_back('{k, 1'b0, 1'b1, exp, c + 2 + lat});
        mq.push_back('{k, 4'h0, ra, 32'h0, c + 1});
        wait_rsp(k);
        idle(k);
    endtask

    task automatic er(int k, logic [31:0] a);
        int c = cyc_n;
        req(k, 1'b1, a, 32'hFFFF_FFFF, 4'hF);
        rq.push_back('{k, 1'b1, 1'b0, 32'h0, c + 1});
        wait_rsp(k);
        idle(k);
    endtask

    task automatic chk_zero(int k);
        chk("zero_ack", 32'(s_ack[k]), 32'h0);
        chk("zero_err", 32'(s_err[k]), 32'h0);
        chk("zero_ram_en", 32'(r_en[k]), 32'h0);
        chk("zero_ram_we", 32'(r_we[k]), 32'h0);
        chk("zero_ram_addr", 32'(r_addr[k]), 32'h0);
        chk("zero_ram_wdata", r_wdata[k], 32'h0);
        chk("zero_dat", s_dat[k], 32'h0);
    endtask

    initial begin
        int c;
        for (int k = 0; k < 2; k++) begin
            idle(k);
            m_adr[k] = 32'h0;
            m_dat[k] = 32'h0;
            m_sel[k] = 4'h0;
        end
        step(3);
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        step(1);
        // instance 0: full, partial and empty byte-lane writes with readback
        wr(0, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 12'h005, 1'b0);
        rd(0, 32'h0000_0014, 32'hDEAD_BEEF, 12'h005);
        wr(0, 32'h0000_0014, 32'h1234_5678, 4'b0011, 12'h005, 1'b0);
        rd(0, 32'h0000_0014, 32'hDEAD_5678, 12'h005);
        wr(0, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 12'h005, 1'b0);
        rd(0, 32'h0000_0014, 32'hDEAD_5678, 12'h005);
        // strobe held high across three writes
        wr(0, 32'h0000_0000, 32'h1111_1111, 4'hF, 12'h000, 1'b1);
        wr(0, 32'h0000_0004, 32'h2222_2222, 4'hF, 12'h001, 1'b1);
        wr(0, 32'h0000_0008, 32'h3333_3333, 4'hF, 12'h002, 1'b0);
        rd(0, 32'h0000_0006, 32'h2222_2222, 12'h001);
        rd(0, 32'h0000_0008, 32'h3333_3333, 12'h002);
        er(0, 32'h0000_4000);
        chk("err_keeps_dat_a", s_dat[0], 32'h3333_3333);
        // instance 1: latency 3 and window edges
        wr(1, 32'h1000_0014, 32'hDEAD_BEEF, 4'hF, 12'h005, 1'b0);
        rd(1, 32'h1000_0014, 32'hDEAD_BEEF, 12'h005);
        wr(1, 32'h1000_3FFC, 32'hCAFE_F00D, 4'hF, 12'hFFF, 1'b0);
        rd(1, 32'h1000_3FFF, 32'hCAFE_F00D, 12'hFFF);
        er(1, 32'h1000_4000);
        chk("err_keeps_dat_b", s_dat[1], 32'hCAFE_F00D);
        er(1, 32'h0FFF_FFFC);
        // read aborted by dropping cyc in the first wait cycle, then an immediate write
        c = cyc_n;
        req(1, 1'b0, 32'h1000_0014, 32'h0, 4'hF);
        mq.push_back('{1, 4'h0, 12'h005, 32'h0, c + 1});
        step(2);
        idle(1);
        step(1);
        wr(1, 32'h1000_0018, 32'h0BAD_CAFE, 4'hF, 12'h006, 1'b0);
        chk("abort_keeps_dat", s_dat[1], 32'hCAFE_F00D);
        step(4);
        chk("abort_keeps_dat_late", s_dat[1], 32'hCAFE_F00D);
        // reset while waiting on read data
        c = cyc_n;
        req(1, 1'b0, 32'h1000_0018, 32'h0, 4'hF);
        mq.push_back('{1, 4'h0, 12'h006, 32'h0, c + 1});
        step(2);
        rst = 1'b1;
        idle(1);
        step(1);
        chk_zero(1);
        rst = 1'b0;
        step(6);
        rd(1, 32'h1000_0018, 32'h0BAD_CAFE, 12'h006);
        step(4);
        chk("rsp_queue_empty", rq.size(), 32'h0);
        chk("ram_queue_empty", mq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/wb_bram_ctrl.md
Name: wb_bram_ctrl

Overview:
Parametrised Wishbone classic slave that bridges the CPU/system bus to a synchronous block RAM with configurable read latency. It adds byte-lane write enables, registered single-pulse ack, read-latency wait states, address-window decoding with wb_err_o, and cycle-abort handling. It sits between the Wishbone interconnect and one BRAM macro port, one instance per memory region.

Parameters:
DATA_W, 32, bus/RAM data width; legal values 32 or 64; byte offset BO = log2(DATA_W/8).
ADDR_W, 12, RAM word-address width; RAM depth = 2**ADDR_W words.
RD_LATENCY, 1, RAM cycles from ram_en_o (read) to valid ram_rdata_i; legal range 1..3.
BASE_ADDR, 32'h0000_0000, window base; only bits [31:ADDR_W+BO] are compared.

Ports:
wb_clk_i  in  1  single clock; all logic on rising edge.
wb_rst_i  in  1  reset, synchronous, active-high.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  strobe.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  32  byte address.
wb_dat_i  in  DATA_W  write data.
wb_sel_i  in  DATA_W/8  byte selects.
wb_dat_o  out  DATA_W  read data, registered.
wb_ack_o  out  1  normal termination, one-cycle pulse.
wb_err_o  out  1  error termination, one-cycle pulse.
ram_en_o  out  1  RAM port enable.
ram_we_o  out  DATA_W/8  per-byte RAM write enable.
ram_addr_o  out  ADDR_W  RAM word address = wb_adr_i[ADDR_W+BO-1:BO].
ram_wdata_o  out  DATA_W  RAM write data.
ram_rdata_i  in  DATA_W  RAM read data.

Behaviour:
- Reset (wb_rst_i=1 at an edge): FSM -> IDLE; wb_dat_o=0, wb_ack_o=0, wb_err_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, wait counter=0. Takes priority over everything, including mid-transfer; a pending read is dropped with no ack.
- All outputs are registered. No combinational path from Wishbone inputs to outputs.
- FSM states: IDLE, ACCESS, WAIT, RESP, ERR.
- IDLE: wb_cyc_i & wb_stb_i sampled high in cycle c -> latch address, data, sel and we.
  - If the address is outside the window (wb_adr_i[31:ADDR_W+BO] != BASE_ADDR[31:ADDR_W+BO]) -> ERR.
  - Otherwise -> ACCESS.
- ERR (cycle c+1): wb_err_o=1, no RAM access, wb_ack_o=0; -> IDLE.
- ACCESS (cycle c+1): ram_en_o=1; ram_addr_o and ram_wdata_o take the latched values.
  - Write: ram_we_o = latched sel; wb_ack_o=1 in the same cycle; -> IDLE. sel=0 is still acked with ram_we_o=0.
  - Read: ram_we_o=0; counter loads RD_LATENCY; -> WAIT.
- WAIT: ram_en_o=0; counter decrements each cycle. When ram_rdata_i is valid (cycle c+1+RD_LATENCY), capture it into wb_dat_o -> RESP.
- RESP (cycle c+2+RD_LATENCY): wb_ack_o=1; -> IDLE.
- Outputs outside their asserting states: ram_en_o=0, ram_we_o=0, ack=0, err=0. ram_addr_o and ram_wdata_o hold their last value. wb_dat_o holds the last read data and is unchanged by writes or errors.
- ack and err each last exactly one cycle and are never asserted together.
- A new request is sampled only in IDLE, so the cycle after an ack or err is never a response. If stb is still high in IDLE, it is a new request.
- Throughput: a write completes every 2 cycles; a read every RD_LATENCY+3 cycles.
- Abort: wb_cyc_i low while in WAIT -> IDLE next edge; no ack, wb_dat_o unchanged. A write issued in ACCESS is not revoked.
- Address bits [BO-1:0] are ignored (no misalignment error).
- Window is inclusive at both ends: BASE_ADDR and BASE_ADDR + 2**(ADDR_W+BO) - 1 are legal. One byte above the top -> err.

Test Plan:
- Write, DATA_W=32, ADDR_W=12, BASE=0: adr=0x14, dat=0xDEADBEEF, sel=4'hF in cycle c -> cycle c+1: ram_en=1, ram_we=4'hF, ram_addr=5, ram_wdata=0xDEADBEEF, ack=1; cycle c+2: ack=0.
- Read, RD_LATENCY=1, RAM model returns 0xDEADBEEF at word 5: read adr=0x14 -> ram_en only in c+1; wb_dat_o=0xDEADBEEF with ack=1 in c+3, ack low in c+4. Repeat with RD_LATENCY=3 -> ack in c+5.
- Partial write: word 5 holds 0xDEADBEEF; write 0x12345678 with sel=4'b0011 -> ram_we=4'b0011; readback = 0xDEAD5678. sel=0 write -> ack with ram_we=0, data unchanged.
- Window, BASE_ADDR=0x1000_0000: adr=0x1000_3FFC -> ack, ram_addr=0xFFF; adr=0x1000_4000 -> err=1 in c+1, ack=0, ram_en=0, wb_dat_o unchanged.
- Abort/reset: RD_LATENCY=3 read, drop wb_cyc_i in c+2 -> no ack, FSM in IDLE at c+3, next write acks normally. Assert wb_rst_i in WAIT -> all outputs 0 the following cycle, no ack.
- Back-to-back: stb held high across 3 writes to words 0,1,2 -> acks in c+1, c+3, c+5, never two consecutive ack cycles.
